// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load extension, regfile write port,
// retire strobe and last-commit bypass record. Optional perf counters: WB_PERF_CNT_EN.
module writeback_stage #(
    parameter int REG_ID_WIDTH = 5,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    StallW,
    input  logic                    FlushW,
    input  logic                    ValidM,
    input  logic                    RegWriteM,
    input  logic                    MemtoRegM,
    input  logic [2:0]              LoadTypeM,
    input  logic [31:0]             ReadDataM,
    input  logic [31:0]             ALUOutM,
    input  logic [REG_ID_WIDTH-1:0] WriteRegM,
`ifdef WB_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]    RetireCntW,
    output logic [CNT_WIDTH-1:0]    LoadCntW,
`endif
    output logic                    RegWriteW,
    output logic [REG_ID_WIDTH-1:0] WriteRegW,
    output logic [31:0]             ResultW,
    output logic                    RetireW,
    output logic                    AlignErrW,
    output logic                    BypValidW,
    output logic [REG_ID_WIDTH-1:0] BypRegW,
    output logic [31:0]             BypDataW
);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    logic                    v_q;
    logic                    regwrite_q;
    logic                    memtoreg_q;
    logic [2:0]              loadtype_q;
    logic [31:0]             readdata_q;
    logic [31:0]             aluout_q;
    logic [REG_ID_WIDTH-1:0] writereg_q;
    logic                    done_q;
    logic                    byp_valid_q;
    logic [REG_ID_WIDTH-1:0] byp_reg_q;
    logic [31:0]             byp_data_q;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        is_half;
    logic        is_word;
    logic        align_err;
    logic        reg_write;
    logic        retire;

    // MEM/WB register: reset > flush > stall > load; done marks a retired slot
    always_ff @(posedge clk) begin
        if (reset || FlushW) begin
            v_q        <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            loadtype_q <= 3'd0;
            readdata_q <= 32'd0;
            aluout_q   <= 32'd0;
            writereg_q <= '0;
            done_q     <= 1'b0;
        end else if (StallW) begin
            done_q     <= done_q | v_q;
        end else begin
            v_q        <= ValidM;
            regwrite_q <= RegWriteM;
            memtoreg_q <= MemtoRegM;
            loadtype_q <= LoadTypeM;
            readdata_q <= ReadDataM;
            aluout_q   <= ALUOutM;
            writereg_q <= WriteRegM;
            done_q     <= 1'b0;
        end
    end

    // Select and extend the loaded byte/half from the registered word
    always_comb begin
        byte_sel = readdata_q[7:0];
        case (aluout_q[1:0])
            2'd0:    byte_sel = readdata_q[7:0];
            2'd1:    byte_sel = readdata_q[15:8];
            2'd2:    byte_sel = readdata_q[23:16];
            default: byte_sel = readdata_q[31:24];
        endcase
        half_sel = aluout_q[1] ? readdata_q[31:16] : readdata_q[15:0];
        is_half  = (loadtype_q == LT_LH) || (loadtype_q == LT_LHU);
        is_word  = (loadtype_q == LT_LW) || (loadtype_q > LT_LHU);
        case (loadtype_q)
            LT_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_ext = {24'd0, byte_sel};
            LT_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_ext = {16'd0, half_sel};
            default: load_ext = readdata_q;
        endcase
    end

    // Alignment check, write enable and retire strobe
    always_comb begin
        align_err = memtoreg_q & v_q &
                    ((is_word & (aluout_q[1:0] != 2'd0)) |
                     (is_half & aluout_q[0]));
        reg_write = v_q & regwrite_q & (writereg_q != '0) & ~align_err;
        retire    = v_q & ~done_q;
    end

    assign RegWriteW = reg_write;
    assign WriteRegW = writereg_q;
    assign ResultW   = memtoreg_q ? load_ext : aluout_q;
    assign RetireW   = retire;
    assign AlignErrW = align_err;
    assign BypValidW = byp_valid_q;
    assign BypRegW   = byp_reg_q;
    assign BypDataW  = byp_data_q;

    // Last-commit record: captured once per instruction, survives flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            byp_valid_q <= 1'b0;
            byp_reg_q   <= '0;
            byp_data_q  <= 32'd0;
        end else if (reg_write && !done_q) begin
            byp_valid_q <= 1'b1;
            byp_reg_q   <= writereg_q;
            byp_data_q  <= ResultW;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] ret_cnt_q;
    logic [CNT_WIDTH-1:0] ld_cnt_q;

    // Retire and retired-load counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_cnt_q <= '0;
            ld_cnt_q  <= '0;
        end else if (retire) begin
            ret_cnt_q <= ret_cnt_q + 1'b1;
            if (memtoreg_q) begin
                ld_cnt_q <= ld_cnt_q + 1'b1;
            end
        end
    end

    assign RetireCntW = ret_cnt_q;
    assign LoadCntW   = ld_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized stimulus, behavioural reference model,
// queue scoreboard checked by an independent monitor.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
    logic [2:0]  LoadTypeM;
    logic [31:0] ReadDataM, ALUOutM;
    logic [4:0]  WriteRegM;
    logic        RegWriteW, RetireW, AlignErrW, BypValidW;
    logic [4:0]  WriteRegW, BypRegW;
    logic [31:0] ResultW, BypDataW;
`ifdef WB_PERF_CNT_EN
    logic [31:0] RetireCntW, LoadCntW;
`endif

    always #5 clk = ~clk;

    writeback_stage #(.REG_ID_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .LoadTypeM(LoadTypeM), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM),
        .WriteRegM(WriteRegM),
`ifdef WB_PERF_CNT_EN
        .RetireCntW(RetireCntW), .LoadCntW(LoadCntW),
`endif
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .RetireW(RetireW), .AlignErrW(AlignErrW), .BypValidW(BypValidW),
        .BypRegW(BypRegW), .BypDataW(BypDataW)
    );

    typedef struct {
        bit          v, rw, m2r;
        int unsigned lt;
        logic [31:0] rd, alu;
        int unsigned wr;
    } instr_t;

    typedef struct {
        bit          rwW, ret, ae, bv;
        int unsigned wrW, br;
        logic [31:0] res, bd, rc, lc;
    } exp_t;

    instr_t      wb;
    bit          retired;
    bit          byp_v;
    int unsigned byp_r;
    logic [31:0] byp_d, cnt_ret, cnt_ld;
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [31:0] load_val(instr_t i);
        int unsigned b, h;
        b = (i.rd >> (8 * (i.alu % 4))) & 255;
        h = (i.rd >> (16 * ((i.alu / 2) % 2))) & 65535;
        case (i.lt)
            1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            2: return 32'(b);
            3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            4: return 32'(h);
            default: return i.rd;
        endcase
    endfunction

    function automatic bit misaligned(instr_t i);
        if (!(i.m2r && i.v)) return 0;
        if (i.lt == 3 || i.lt == 4) return (i.alu % 2) != 0;
        if (i.lt == 1 || i.lt == 2) return 0;
        return (i.alu % 4) != 0;
    endfunction

    function automatic exp_t outputs();
        exp_t e;
        e.ae  = misaligned(wb);
        e.res = wb.m2r ? load_val(wb) : wb.alu;
        e.rwW = wb.v && wb.rw && wb.wr != 0 && !e.ae;
        e.wrW = wb.wr;
        e.ret = wb.v && !retired;
        e.bv  = byp_v;
        e.br  = byp_r;
        e.bd  = byp_d;
        e.rc  = cnt_ret;
        e.lc  = cnt_ld;
        return e;
    endfunction

    task automatic model_edge(bit r, bit st, bit fl, instr_t nx);
        exp_t cur;
        cur = outputs();
        if (r) begin
            wb = '{default: 0};
            retired = 0;
            byp_v = 0; byp_r = 0; byp_d = 0;
            cnt_ret = 0; cnt_ld = 0;
            return;
        end
        if (cur.rwW && !retired) begin
            byp_v = 1; byp_r = cur.wrW; byp_d = cur.res;
        end
        if (cur.ret) begin
            cnt_ret++;
            if (wb.m2r) cnt_ld++;
        end
        if (fl) begin
            wb = '{default: 0};
            retired = 0;
        end else if (st) begin
            retired = retired | wb.v;
        end else begin
            wb = nx;
            retired = 0;
        end
    endtask

    task automatic step(bit r, bit st, bit fl, bit v, bit rw, bit m2r,
                        int unsigned lt, logic [31:0] rd, logic [31:0] alu,
                        int unsigned wr);
        instr_t nx;
        @(negedge clk);
        reset = r; StallW = st; FlushW = fl;
        ValidM = v; RegWriteM = rw; MemtoRegM = m2r;
        LoadTypeM = 3'(lt); ReadDataM = rd; ALUOutM = alu; WriteRegM = 5'(wr);
        nx = '{v: v, rw: rw, m2r: m2r, lt: lt, rd: rd, alu: alu, wr: wr};
        model_edge(r, st, fl, nx);
        sb.push_back(outputs());
    endtask

    task automatic idle(bit r, bit st, bit fl);
        step(r, st, fl, 0, 0, 0, 0, 32'd0, 32'd0, 0);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one expected record per clock edge, compared 1 time unit later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("RegWriteW", 32'(RegWriteW), 32'(e.rwW));
                chk("WriteRegW", 32'(WriteRegW), e.wrW);
                chk("ResultW",   ResultW,        e.res);
                chk("RetireW",   32'(RetireW),   32'(e.ret));
                chk("AlignErrW", 32'(AlignErrW), 32'(e.ae));
                chk("BypValidW", 32'(BypValidW), 32'(e.bv));
                chk("BypRegW",   32'(BypRegW),   e.br);
                chk("BypDataW",  BypDataW,       e.bd);
`ifdef WB_PERF_CNT_EN
                chk("RetireCntW", RetireCntW, e.rc);
                chk("LoadCntW",   LoadCntW,   e.lc);
`endif
            end
        end
    end

    initial begin
        int unsigned wait_cyc;
        wb = '{default: 0};
        retired = 0; byp_v = 0; byp_r = 0; byp_d = 0;
        cnt_ret = 0; cnt_ld = 0;
        reset = 1; StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0;
        MemtoRegM = 0; LoadTypeM = 0; ReadDataM = 0; ALUOutM = 0; WriteRegM = 0;

        idle(1, 0, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);
        // ALU writeback, then bubble so bypass record is visible
        step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0000_002A, 8);
        idle(0, 0, 0);
        // load extension cases
        step(0, 0, 0, 1, 1, 1, 1, 32'h80FF_7F01, 32'h0000_1003, 9);
        step(0, 0, 0, 1, 1, 1, 2, 32'h80FF_7F01, 32'h0000_1001, 10);
        step(0, 0, 0, 1, 1, 1, 3, 32'h80FF_7F01, 32'h0000_1002, 11);
        step(0, 0, 0, 1, 1, 1, 4, 32'h80FF_7F01, 32'h0000_1000, 12);
        step(0, 0, 0, 1, 1, 1, 0, 32'h1234_5678, 32'h0000_1004, 13);
        // misaligned lw and lh
        step(0, 0, 0, 1, 1, 1, 0, 32'hDEAD_BEEF, 32'h0000_1002, 14);
        step(0, 0, 0, 1, 1, 1, 3, 32'hDEAD_BEEF, 32'h0000_1001, 15);
        // write to $zero
        step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0055, 0);
        // stall for 3 cycles with a valid instruction held
        step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0077, 5);
        step(0, 1, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0999, 6);
        step(0, 1, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0999, 6);
        step(0, 1, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0999, 6);
        // stall and flush together load a bubble
        step(0, 1, 1, 1, 1, 0, 0, 32'h0, 32'h0000_0999, 6);
        idle(0, 0, 0);
        // reset asserted mid-stall
        step(0, 0, 0, 1, 1, 1, 0, 32'hCAFE_0000, 32'h0000_2000, 7);
        idle(0, 1, 0);
        idle(1, 1, 0);
        idle(0, 0, 0);
        // 4 retires, 2 of them loads, then reset
        step(0, 0, 0, 1, 1, 1, 1, 32'h0000_0080, 32'h0, 1);
        step(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h11, 2);
        step(0, 0, 0, 1, 1, 1, 4, 32'hFFFF_0000, 32'h2, 3);
        step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h22, 4);
        idle(0, 0, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, st, fl;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 8);
            step(r, st, fl, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom, $urandom, $urandom_range(0, 31));
        end
        idle(0, 0, 0);

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (WB) pipeline stage, directly downstream of the memory stage.
- Holds the MEM/WB pipeline register with stall/flush, and extends load data per load type.
- Produces ResultW and the register-file write port (RegWriteW/WriteRegW/ResultW) that drives decode writeback and execute forwarding.
- Keeps a registered last-commit bypass record for decode, and a retire strobe that fires once per instruction even across stalls.

Parameters:
- REG_ID_WIDTH, 5, register index width.
- CNT_WIDTH, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallW  in  1  hold the MEM/WB register
- FlushW  in  1  load a bubble into the MEM/WB register
- ValidM  in  1  MEM slot holds a real instruction
- RegWriteM  in  1  instruction writes a register
- MemtoRegM  in  1  result comes from memory read data
- LoadTypeM  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; 5-7 treated as lw
- ReadDataM  in  32  raw data-memory word
- ALUOutM  in  32  ALU result / memory address
- WriteRegM  in  REG_ID_WIDTH  destination register
- RegWriteW  out  1  register-file write enable
- WriteRegW  out  REG_ID_WIDTH  register-file write index
- ResultW  out  32  writeback value (to register file and forwarding)
- RetireW  out  1  one-cycle pulse per retired instruction
- AlignErrW  out  1  misaligned load detected (held while the instruction sits in WB)
- BypValidW  out  1  last-commit bypass record valid
- BypRegW  out  REG_ID_WIDTH  register index of the last commit
- BypDataW  out  32  data of the last commit

Behaviour:
- Pipeline register (posedge clk), priority reset > FlushW > StallW > load:
  - reset or FlushW: V=0, RegWrite=0, all data fields 0.
  - StallW: hold all fields.
  - otherwise: capture every M input.
- Latency: an instruction captured at edge N is presented on the W outputs during cycle N..N+1. No combinational path from M inputs to W outputs.
- Load extension, combinational from registered fields; byte offset = ALUOut[1:0]:
  - lb/lbu: select byte at that offset; sign-extend (lb) or zero-extend (lbu).
  - lh/lhu: select half by ALUOut[1]; sign-extend (lh) or zero-extend (lhu).
  - lw: word unchanged.
- Alignment:
  - AlignErr = MemtoReg & V & (lw with ALUOut[1:0]≠0, or lh/lhu with ALUOut[0]=1).
  - A misaligned load does not write the register file.
- ResultW = MemtoReg ? extended load data : ALUOut.
- RegWriteW = V & RegWrite & (WriteReg≠0) & ~AlignErr. Writes to $zero are suppressed.
- WriteRegW is always driven from the register, including when RegWriteW=0.
- Write-once/retire flag `done`:
  - Set on the first cycle an instruction with V=1 is in WB.
  - Cleared when a new instruction is loaded, on flush, or on reset.
  - RetireW = V & ~done: exactly one pulse per instruction, however long StallW holds it.
  - Misaligned loads still retire.
  - RegWriteW stays asserted while held (register-file write is idempotent).
- Bypass record, updated at posedge when RegWriteW & ~done:
  - BypValidW←1, BypRegW←WriteRegW, BypDataW←ResultW.
  - Otherwise hold.
  - Cleared only by reset; FlushW does not clear it.
- Reset values: all outputs 0.
- Reset asserted mid-stall discards the held instruction; no retire pulse is issued for it.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined: adds outputs RetireCntW [CNT_WIDTH] and LoadCntW [CNT_WIDTH].
  - RetireCntW increments on RetireW.
  - LoadCntW increments on RetireW & MemtoReg.
  - Both wrap modulo 2^CNT_WIDTH and are reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU writeback: ValidM=1, RegWriteM=1, MemtoRegM=0, ALUOutM=0x0000_002A, WriteRegM=8 → next cycle RegWriteW=1, WriteRegW=8, ResultW=0x2A, RetireW=1 for one cycle; BypRegW=8, BypDataW=0x2A one cycle later.
- Load extension: ReadDataM=0x80FF_7F01 with lb @ALUOut=0x..3 → ResultW=0xFFFF_FF80; lbu @0x..1 → 0x0000_007F; lh @0x..2 → 0xFFFF_80FF; lhu @0x..0 → 0x0000_7F01.
- Misaligned: lw with ALUOutM=0x1002 → AlignErrW=1, RegWriteW=0, RetireW pulses once, bypass record unchanged.
- $zero: RegWriteM=1, WriteRegM=0 → RegWriteW=0, RetireW=1, BypValidW unchanged.
- Stall/flush: hold StallW=1 for 3 cycles with a valid instruction in WB → exactly one RetireW pulse, outputs stable; StallW=1 & FlushW=1 together → bubble loaded (RegWriteW=0, RetireW=0).
- Reset: assert reset mid-stall → next cycle all outputs 0; with WB_PERF_CNT_EN, after 4 retires including 2 loads → RetireCntW=4, LoadCntW=2, both 0 after reset.
